// File: rtl/homo_stream_ctrl_pkg.sv
// homo_stream_ctrl_pkg
// Shared configuration for the homomorphic envelogram datapath
// (log -> Butterworth LP -> exp) and its stream sequencer.
// Contents:
//   - stage counts of the log, filter and exp blocks, and the total datapath
//     latency derived from them
//   - fixed-point format and the fixed-point ONE (ln(ONE) = 0), which is the
//     word driven into the datapath when no sample is issued
//   - state encoding of the stream sequencer FSM
package homo_stream_ctrl_pkg;

  localparam int LOG_N_STAGES = 6;
  localparam int FILT_LATENCY = 4;
  localparam int EXP_N_STAGES = 6;

  // Cycles from the datapath sampling its input to the matching output.
  localparam int DP_PIPE_LATENCY = LOG_N_STAGES + FILT_LATENCY + EXP_N_STAGES;

  localparam int          FX_FRAC_BITS = 12;
  localparam logic [31:0] FX_ONE       = 32'(1) << FX_FRAC_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stream_state_t;

endpackage

// File: rtl/homo_result_fifo.sv
// homo_result_fifo
// First-word fall-through result buffer. The head entry is always visible on
// o_data; o_count reports occupancy. The owner guarantees no push when full.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (clears pointers and count)
//   i_push   write i_data this cycle
//   i_data   write data
//   i_pop    consume the head entry (ignored when empty)
//   o_data   head entry (stale when empty)
//   o_count  number of stored entries, 0..DEPTH
module homo_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only valid entries are ever presented.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_count_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_count <= CW'(DEPTH));

  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/homo_stream_ctrl.sv
// homo_stream_ctrl
// Frame sequencer for the homomorphic envelogram datapath. Accepts samples over
// valid/ready, issues them into the fixed-latency non-stallable datapath,
// tracks them with a tag pipe and buffers results in a FWFT FIFO. Issue is
// gated by credits so a result always has a FIFO slot when it comes out.
// Ports:
//   CLK, RST              clock, synchronous active-low reset
//   start, frame_len      start a frame of frame_len samples (IDLE/DONE only)
//   busy, done            frame in progress / frame complete
//   in_data/valid/ready   sample input stream
//   dp_data               datapath input (IDLE_WORD when nothing issued)
//   dp_we, dp_out         datapath output valid and data
//   out_data/valid/ready  result output stream (FIFO head)
//   sync_err              sticky: tag exited without dp_we
module homo_stream_ctrl
  import homo_stream_ctrl_pkg::*;
#(
  parameter int          PIPE_LATENCY = DP_PIPE_LATENCY,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          LEN_W        = 16,
  parameter logic [31:0] IDLE_WORD    = FX_ONE
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      dp_data,
  input  logic             dp_we,
  input  logic [31:0]      dp_out,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err
);

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  // Tag stage 0 travels with the registered dp_data word; the remaining
  // PIPE_LATENCY stages mirror the datapath, so the last stage lines up with
  // the matching dp_out.
  localparam int TAGS = PIPE_LATENCY + 1;
  localparam int IW   = $clog2(TAGS + 1);
  localparam int UW   = $clog2(FIFO_DEPTH + TAGS + 1) + 1;

  stream_state_t    r_state;
  stream_state_t    w_state_next;
  logic [LEN_W-1:0] r_remaining;
  logic [TAGS-1:0]  r_tag;
  logic [31:0]      r_dp_data;
  logic             r_sync_err;

  logic [CW-1:0]    w_fifo_count;
  logic [IW-1:0]    w_inflight;
  logic [UW-1:0]    w_used;
  logic             w_credit_ok;
  logic             w_start_ok;
  logic             w_issue;
  logic             w_tag_exit;
  logic             w_pop;
  logic             w_busy;
  logic             w_done;
  logic             w_in_ready;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_issue    = in_valid && w_in_ready;
  assign w_tag_exit = r_tag[TAGS-1];
  assign w_pop      = (w_fifo_count != '0) && out_ready;

  // Every set tag already owns a FIFO slot, so issue only while occupancy plus
  // in-flight samples stays below the FIFO depth.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < TAGS; i++) begin
      w_inflight = w_inflight + IW'(r_tag[i]);
    end
  end

  assign w_used      = UW'(w_fifo_count) + UW'(w_inflight);
  assign w_credit_ok = w_used < UW'(FIFO_DEPTH);

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_next = (frame_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if ((r_remaining == '0) || (w_issue && (r_remaining == LEN_W'(1))))
          w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_tag == '0) && (w_fifo_count == '0)) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    w_done     = (r_state == ST_DONE);
    w_in_ready = (r_state == ST_RUN) && (r_remaining != '0) && w_credit_ok;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_remaining <= '0;
      r_tag       <= '0;
      r_dp_data   <= IDLE_WORD;
      r_sync_err  <= 1'b0;
    end else begin
      r_tag     <= {r_tag[TAGS-2:0], w_issue};
      r_dp_data <= w_issue ? in_data : IDLE_WORD;
      if (w_start_ok)
        r_remaining <= frame_len;
      else if (w_issue && (r_remaining != '0))
        r_remaining <= r_remaining - LEN_W'(1);
      if (w_start_ok)
        r_sync_err <= 1'b0;
      else if (w_tag_exit && !dp_we)
        r_sync_err <= 1'b1;
    end
  end

  // Results are pushed on tag exit regardless of dp_we; a missing dp_we is
  // only flagged so the frame still delivers the expected number of results.
  homo_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (w_tag_exit),
    .i_data  (dp_out),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_count (w_fifo_count)
  );

  assign busy      = w_busy;
  assign done      = w_done;
  assign in_ready  = w_in_ready;
  assign dp_data   = r_dp_data;
  assign out_valid = (w_fifo_count != '0);
  assign sync_err  = r_sync_err;

endmodule
